// File: rtl/alu_uart_frame_ctrl.sv
// -----------------------------------------------------------------------------
// alu_uart_frame_ctrl
//
// Frame controller sitting between the UART RX/TX FIFOs and a combinational
// ALU. A frame is one opcode byte followed by operand A and operand B, each
// NB_OPERAND bits sent LSB byte first. Once the last byte of B arrives, the
// opcode and both operands are presented to the ALU in the same cycle. The
// ALU result is then sent back LSB byte first into the TX FIFO, which may
// apply backpressure. A frame that stalls mid-operand for TIMEOUT_CYCLES
// consecutive empty cycles is aborted.
//
// Handshakes:
//   RX: i_rx_data is valid whenever i_rx_empty=0 (first-word-fall-through).
//       A byte is consumed on the rising edge where o_rx_rd=1.
//   TX: a byte is accepted on the rising edge where o_tx_wr=1. o_tx_wr is
//       never raised while i_tx_full=1.
//
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_rx_data, i_rx_empty   RX FIFO head byte and empty flag
//   o_rx_rd                 RX pop strobe
//   i_tx_full               TX FIFO full flag
//   o_tx_wr, o_tx_data      TX push strobe and byte
//   i_alu_result            combinational ALU result
//   o_alu_op/a/b            latched opcode and operands driving the ALU
//   o_busy                  high whenever the controller is not in IDLE
//   o_done                  one-cycle pulse after the final result byte push
//   o_timeout               one-cycle pulse after a mid-frame abort
// -----------------------------------------------------------------------------
module alu_uart_frame_ctrl #(
    parameter int NB_DATA        = 8,
    parameter int NB_OP          = 6,
    parameter int NB_OPERAND     = 16,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [NB_DATA-1:0]    i_rx_data,
    input  logic                  i_rx_empty,
    output logic                  o_rx_rd,
    input  logic                  i_tx_full,
    output logic                  o_tx_wr,
    output logic [NB_DATA-1:0]    o_tx_data,
    input  logic [NB_OPERAND-1:0] i_alu_result,
    output logic [NB_OP-1:0]      o_alu_op,
    output logic [NB_OPERAND-1:0] o_alu_a,
    output logic [NB_OPERAND-1:0] o_alu_b,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_timeout
);

    localparam int NBYTES = NB_OPERAND / NB_DATA;
    localparam int NB_CNT = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(NBYTES - 1);
    localparam int NB_TO  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    // Value of the empty-cycle counter on the last allowed empty cycle.
    localparam logic [NB_TO-1:0] TO_LAST =
        (TIMEOUT_CYCLES > 0) ? NB_TO'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GET_A = 3'd1,
        S_GET_B = 3'd2,
        S_EXEC  = 3'd3,
        S_SEND  = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;

    logic [NB_CNT-1:0]       r_cnt;
    logic [NB_TO-1:0]        r_to_cnt;
    logic [NB_OP-1:0]        r_op_stage;
    logic [NB_OPERAND-1:0]   r_a_stage;
    logic [NB_OPERAND-1:0]   r_b_stage;
    logic [NB_OPERAND-1:0]   r_res;
    logic [NB_OP-1:0]        r_alu_op;
    logic [NB_OPERAND-1:0]   r_alu_a;
    logic [NB_OPERAND-1:0]   r_alu_b;
    logic                    r_done;
    logic                    r_timeout;

    logic                    w_rx_rd;
    logic                    w_tx_wr;
    logic                    w_busy;
    logic                    w_in_get;
    logic                    w_last_byte;
    logic                    w_to_hit;
    logic [NB_OPERAND-1:0]   w_a_merged;
    logic [NB_OPERAND-1:0]   w_b_merged;

    assign w_in_get    = (r_state == S_GET_A) || (r_state == S_GET_B);
    assign w_last_byte = (r_cnt == CNT_LAST);
    // Abort on the TIMEOUT_CYCLES-th consecutive empty cycle while collecting
    // operands; the counter holds the number of preceding empty cycles.
    assign w_to_hit    = (TIMEOUT_CYCLES > 0) && w_in_get && i_rx_empty &&
                         (r_to_cnt == TO_LAST);

    // Staging with the incoming byte dropped into its slot, so the final B
    // byte can reach the ALU operand register on the same edge it is popped.
    always_comb begin
        w_a_merged = r_a_stage;
        w_a_merged[r_cnt*NB_DATA +: NB_DATA] = i_rx_data;
        w_b_merged = r_b_stage;
        w_b_merged[r_cnt*NB_DATA +: NB_DATA] = i_rx_data;
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = S_IDLE;
        case (r_state)
            S_IDLE: begin
                w_next_state = w_rx_rd ? S_GET_A : S_IDLE;
            end
            S_GET_A: begin
                w_next_state = S_GET_A;
                if (w_rx_rd && w_last_byte) begin
                    w_next_state = S_GET_B;
                end else if (w_to_hit) begin
                    w_next_state = S_IDLE;
                end
            end
            S_GET_B: begin
                w_next_state = S_GET_B;
                if (w_rx_rd && w_last_byte) begin
                    w_next_state = S_EXEC;
                end else if (w_to_hit) begin
                    w_next_state = S_IDLE;
                end
            end
            S_EXEC: begin
                w_next_state = S_SEND;
            end
            S_SEND: begin
                w_next_state = (w_tx_wr && w_last_byte) ? S_IDLE : S_SEND;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Output logic; unknown encodings leave every strobe low.
    always_comb begin
        w_rx_rd = 1'b0;
        w_tx_wr = 1'b0;
        w_busy  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_rx_rd = ~i_rx_empty;
            end
            S_GET_A, S_GET_B: begin
                w_rx_rd = ~i_rx_empty;
                w_busy  = 1'b1;
            end
            S_EXEC: begin
                w_busy  = 1'b1;
            end
            S_SEND: begin
                w_tx_wr = ~i_tx_full;
                w_busy  = 1'b1;
            end
            default: begin
                w_busy  = 1'b0;
            end
        endcase
    end

    // Datapath: counters, staging, ALU operand latches and result shifter.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt      <= '0;
            r_to_cnt   <= '0;
            r_op_stage <= '0;
            r_a_stage  <= '0;
            r_b_stage  <= '0;
            r_res      <= '0;
            r_alu_op   <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_done    <= (r_state == S_SEND) && w_tx_wr && w_last_byte;
            r_timeout <= w_to_hit;

            if (w_next_state != r_state) begin
                r_cnt <= '0;
            end else if (w_rx_rd || w_tx_wr) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if ((w_next_state != r_state) || w_rx_rd) begin
                r_to_cnt <= '0;
            end else if (w_in_get && i_rx_empty) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_rx_rd) begin
                        r_op_stage <= i_rx_data[NB_OP-1:0];
                    end
                end
                S_GET_A: begin
                    if (w_rx_rd) begin
                        r_a_stage <= w_a_merged;
                    end
                end
                S_GET_B: begin
                    if (w_rx_rd) begin
                        r_b_stage <= w_b_merged;
                        if (w_last_byte) begin
                            r_alu_op <= r_op_stage;
                            r_alu_a  <= r_a_stage;
                            r_alu_b  <= w_b_merged;
                        end
                    end
                end
                S_EXEC: begin
                    r_res <= i_alu_result;
                end
                S_SEND: begin
                    if (w_tx_wr) begin
                        r_res <= r_res >> NB_DATA;
                    end
                end
                default: begin
                    r_res <= r_res;
                end
            endcase

            // Partial operands from an aborted frame must not leak anywhere.
            if (w_to_hit) begin
                r_op_stage <= '0;
                r_a_stage  <= '0;
                r_b_stage  <= '0;
            end
        end
    end

    assign o_rx_rd   = w_rx_rd;
    assign o_tx_wr   = w_tx_wr;
    assign o_tx_data = r_res[NB_DATA-1:0];
    assign o_alu_op  = r_alu_op;
    assign o_alu_a   = r_alu_a;
    assign o_alu_b   = r_alu_b;
    assign o_busy    = w_busy;
    assign o_done    = r_done;
    assign o_timeout = r_timeout;

endmodule

// File: tb/tb_alu_uart_frame_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for alu_uart_frame_ctrl with 16-bit operands and a 10-cycle timeout.
// An RX FIFO model feeds frame bytes, the ALU is an adder built from the
// DUT's operand outputs, and a cycle model of the frame protocol predicts
// every strobe. Expected TX bytes are queued when a frame is fully popped
// and compared as the DUT pushes them.
// -----------------------------------------------------------------------------
module tb_alu_uart_frame_ctrl;

    localparam int NB_DATA    = 8;
    localparam int NB_OP      = 6;
    localparam int NB_OPERAND = 16;
    localparam int TO_CYCLES  = 10;
    localparam int FRAME_LEN  = 5;

    // ---------------- clock / reset / DUT ----------------
    logic                  clk = 1'b0;
    logic                  i_reset = 1'b1;
    logic [NB_DATA-1:0]    i_rx_data = '0;
    logic                  i_rx_empty = 1'b1;
    logic                  o_rx_rd;
    logic                  i_tx_full = 1'b0;
    logic                  o_tx_wr;
    logic [NB_DATA-1:0]    o_tx_data;
    logic [NB_OPERAND-1:0] alu_result;
    logic [NB_OP-1:0]      o_alu_op;
    logic [NB_OPERAND-1:0] o_alu_a;
    logic [NB_OPERAND-1:0] o_alu_b;
    logic                  o_busy;
    logic                  o_done;
    logic                  o_timeout;

    always #5 clk = ~clk;

    assign alu_result = o_alu_a + o_alu_b;

    alu_uart_frame_ctrl #(
        .NB_DATA(NB_DATA), .NB_OP(NB_OP),
        .NB_OPERAND(NB_OPERAND), .TIMEOUT_CYCLES(TO_CYCLES)
    ) dut (
        .i_clk(clk), .i_reset(i_reset),
        .i_rx_data(i_rx_data), .i_rx_empty(i_rx_empty), .o_rx_rd(o_rx_rd),
        .i_tx_full(i_tx_full), .o_tx_wr(o_tx_wr), .o_tx_data(o_tx_data),
        .i_alu_result(alu_result),
        .o_alu_op(o_alu_op), .o_alu_a(o_alu_a), .o_alu_b(o_alu_b),
        .o_busy(o_busy), .o_done(o_done), .o_timeout(o_timeout)
    );

    // ---------------- environment and model state ----------------
    logic [NB_DATA-1:0] rx_q[$];
    logic [NB_DATA-1:0] exp_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit checks_en = 1'b0;

    int gap_len = 0, gap_left = 0;
    bit rx_block = 1'b0;
    bit stall_arm = 1'b0;
    int stall_len = 5, full_left = 0, stall_cycles = 0;
    int done_seen = 0, to_seen = 0;

    bit m_accept = 1'b1, m_exec = 1'b0, m_send = 1'b0;
    bit m_done = 1'b0, m_to = 1'b0;
    int m_idx = 0, m_push = 0, m_empty = 0;
    logic [NB_DATA-1:0] fb[FRAME_LEN];
    logic [NB_OP-1:0]      exp_op = '0;
    logic [NB_OPERAND-1:0] exp_a = '0, exp_b = '0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic set_inputs();
        i_rx_empty = rx_block || (rx_q.size() == 0) || (gap_left > 0);
        i_rx_data  = i_rx_empty ? NB_DATA'($urandom) : rx_q[0];
        i_tx_full  = (full_left > 0);
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [15:0] a,
                              input logic [15:0] b);
        rx_q.push_back(op);
        rx_q.push_back(a[7:0]);
        rx_q.push_back(a[15:8]);
        rx_q.push_back(b[7:0]);
        rx_q.push_back(b[15:8]);
        set_inputs();
    endtask

    // One clock cycle: compare strobes/scoreboard at the falling edge,
    // advance the protocol model, then update stimulus after the rising edge.
    task automatic step();
        bit exp_rx_rd, exp_tx_wr, exp_busy, smp_rd, n_done, n_to, enter_send;
        logic [15:0] sa, sb, sum;
        @(negedge clk);
        cyc++;
        exp_rx_rd = m_accept && !i_rx_empty;
        exp_tx_wr = m_send && !i_tx_full;
        exp_busy  = !(m_accept && (m_idx == 0));
        if (checks_en) begin
            n_checks++;
            if (o_rx_rd !== exp_rx_rd) begin
                n_errors++;
                $display("FAIL rx_rd cyc %0d: got %b want %b", cyc, o_rx_rd, exp_rx_rd);
            end
            n_checks++;
            if (o_tx_wr !== exp_tx_wr) begin
                n_errors++;
                $display("FAIL tx_wr cyc %0d: got %b want %b", cyc, o_tx_wr, exp_tx_wr);
            end
            n_checks++;
            if (o_busy !== exp_busy) begin
                n_errors++;
                $display("FAIL busy cyc %0d: got %b want %b", cyc, o_busy, exp_busy);
            end
            n_checks++;
            if (o_done !== m_done) begin
                n_errors++;
                $display("FAIL done cyc %0d: got %b want %b", cyc, o_done, m_done);
            end
            n_checks++;
            if (o_timeout !== m_to) begin
                n_errors++;
                $display("FAIL timeout cyc %0d: got %b want %b", cyc, o_timeout, m_to);
            end
            n_checks++;
            if ({o_alu_op, o_alu_a, o_alu_b} !== {exp_op, exp_a, exp_b}) begin
                n_errors++;
                $display("FAIL alu_ports cyc %0d: got op=%h a=%h b=%h want op=%h a=%h b=%h",
                         cyc, o_alu_op, o_alu_a, o_alu_b, exp_op, exp_a, exp_b);
            end
            if (m_send) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL tx_data cyc %0d: got %h want none queued", cyc, o_tx_data);
                end else if (o_tx_data !== exp_q[0]) begin
                    n_errors++;
                    $display("FAIL tx_data cyc %0d: got %h want %h", cyc, o_tx_data, exp_q[0]);
                end
            end
        end
        if (o_done === 1'b1) done_seen++;
        if (o_timeout === 1'b1) to_seen++;
        if (m_send && i_tx_full) stall_cycles++;
        smp_rd = o_rx_rd;

        n_done = 1'b0;
        n_to = 1'b0;
        enter_send = 1'b0;
        if (i_reset) begin
            m_accept = 1'b1; m_exec = 1'b0; m_send = 1'b0;
            m_idx = 0; m_push = 0; m_empty = 0;
            exp_op = '0; exp_a = '0; exp_b = '0;
            exp_q.delete();
        end else if (m_accept) begin
            if (exp_rx_rd) begin
                fb[m_idx] = i_rx_data;
                m_idx++;
                m_empty = 0;
                if (m_idx == FRAME_LEN) begin
                    sa = {fb[2], fb[1]};
                    sb = {fb[4], fb[3]};
                    sum = sa + sb;
                    exp_op = fb[0][NB_OP-1:0];
                    exp_a = sa;
                    exp_b = sb;
                    exp_q.push_back(sum[7:0]);
                    exp_q.push_back(sum[15:8]);
                    m_accept = 1'b0;
                    m_exec = 1'b1;
                    m_idx = 0;
                end
            end else if ((m_idx > 0) && i_rx_empty) begin
                m_empty++;
                if (m_empty == TO_CYCLES) begin
                    m_idx = 0;
                    m_empty = 0;
                    n_to = 1'b1;
                end
            end
        end else if (m_exec) begin
            m_exec = 1'b0;
            m_send = 1'b1;
            m_push = 0;
            enter_send = 1'b1;
        end else if (m_send) begin
            if (exp_tx_wr) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                m_push++;
                if (m_push == NB_OPERAND / NB_DATA) begin
                    m_send = 1'b0;
                    m_accept = 1'b1;
                    n_done = 1'b1;
                end
            end
        end
        m_done = n_done;
        m_to = n_to;

        @(posedge clk);
        #1;
        if (smp_rd && rx_q.size() > 0) begin
            void'(rx_q.pop_front());
            gap_left = gap_len;
        end else if (gap_left > 0) begin
            gap_left--;
        end
        if (full_left > 0) full_left--;
        if (enter_send && stall_arm) full_left = stall_len;
        set_inputs();
    endtask

    task automatic wait_idle(input int budget, input string name);
        int i;
        for (i = 0; i < budget; i++) begin
            step();
            if (rx_q.size() == 0 && m_accept && m_idx == 0 && exp_q.size() == 0) break;
        end
        step();
        n_checks++;
        if (i >= budget) begin
            n_errors++;
            $display("FAIL %s_wait_idle: got no idle after %0d cycles want idle", name, budget);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        checks_en = 1'b0;
        i_reset = 1'b1;
        set_inputs();
        step();
        checks_en = 1'b1;
        step();
        i_reset = 1'b0;
        step();
        n_checks++;
        if ({o_busy, o_done, o_timeout, o_rx_rd, o_tx_wr} !== 5'b0) begin
            n_errors++;
            $display("FAIL reset_strobes: got %b want 00000",
                     {o_busy, o_done, o_timeout, o_rx_rd, o_tx_wr});
        end
        n_checks++;
        if ({o_alu_op, o_alu_a, o_alu_b} !== '0) begin
            n_errors++;
            $display("FAIL reset_alu: got op=%h a=%h b=%h want zeros", o_alu_op, o_alu_a, o_alu_b);
        end
    endtask

    task automatic test_basic_frame();
        int d0 = done_seen, t0 = to_seen;
        send_frame(8'h20, 16'h1234, 16'h0001);
        wait_idle(40, "basic");
        n_checks++;
        if (done_seen - d0 != 1) begin
            n_errors++;
            $display("FAIL basic_done_count: got %0d want 1", done_seen - d0);
        end
        n_checks++;
        if ({o_alu_op, o_alu_a, o_alu_b} !== {6'h20, 16'h1234, 16'h0001}) begin
            n_errors++;
            $display("FAIL basic_alu: got op=%h a=%h b=%h want op=20 a=1234 b=0001",
                     o_alu_op, o_alu_a, o_alu_b);
        end
        n_checks++;
        if (to_seen != t0) begin
            n_errors++;
            $display("FAIL basic_timeout: got %0d pulses want 0", to_seen - t0);
        end
    endtask

    task automatic test_gaps();
        int d0 = done_seen, t0 = to_seen;
        gap_len = 3;
        send_frame(8'h20, 16'h1234, 16'h0001);
        wait_idle(80, "gaps");
        gap_len = 0;
        n_checks++;
        if (done_seen - d0 != 1) begin
            n_errors++;
            $display("FAIL gaps_done_count: got %0d want 1", done_seen - d0);
        end
        n_checks++;
        if (to_seen != t0) begin
            n_errors++;
            $display("FAIL gaps_timeout: got %0d pulses want 0", to_seen - t0);
        end
    endtask

    task automatic test_timeout();
        int t0 = to_seen, d0 = done_seen, i;
        rx_q.push_back(8'h20);
        rx_q.push_back(8'h34);
        set_inputs();
        for (i = 0; i < 40; i++) begin
            step();
            if (to_seen > t0) break;
        end
        n_checks++;
        if (to_seen - t0 != 1) begin
            n_errors++;
            $display("FAIL timeout_pulse: got %0d pulses want 1", to_seen - t0);
        end
        n_checks++;
        if (o_busy !== 1'b0 || {o_alu_a, o_alu_b} !== {16'h1234, 16'h0001}) begin
            n_errors++;
            $display("FAIL timeout_hold: got busy=%b a=%h b=%h want busy=0 a=1234 b=0001",
                     o_busy, o_alu_a, o_alu_b);
        end
        send_frame(8'hC5, 16'hFFFF, 16'h0002);
        wait_idle(40, "after_timeout");
        n_checks++;
        if (done_seen - d0 != 1 || {o_alu_op, o_alu_a, o_alu_b} !== {6'h05, 16'hFFFF, 16'h0002}) begin
            n_errors++;
            $display("FAIL after_timeout_frame: got done=%0d op=%h a=%h b=%h want done=1 op=05 a=ffff b=0002",
                     done_seen - d0, o_alu_op, o_alu_a, o_alu_b);
        end
    endtask

    task automatic test_tx_stall();
        int d0 = done_seen;
        stall_cycles = 0;
        stall_arm = 1'b1;
        stall_len = 5;
        send_frame(8'h07, 16'hABCD, 16'h1111);
        wait_idle(50, "stall");
        stall_arm = 1'b0;
        n_checks++;
        if (stall_cycles != 5) begin
            n_errors++;
            $display("FAIL stall_cycles: got %0d want 5", stall_cycles);
        end
        n_checks++;
        if (done_seen - d0 != 1) begin
            n_errors++;
            $display("FAIL stall_done_count: got %0d want 1", done_seen - d0);
        end
    endtask

    task automatic test_reset_mid_frame();
        int i;
        rx_q.push_back(8'h11);
        rx_q.push_back(8'h22);
        rx_q.push_back(8'h33);
        rx_q.push_back(8'h44);
        set_inputs();
        for (i = 0; i < 20; i++) begin
            step();
            if (m_idx == 4) break;
        end
        n_checks++;
        if (m_idx != 4) begin
            n_errors++;
            $display("FAIL midreset_reach_getb: got %0d bytes want 4", m_idx);
        end
        rx_block = 1'b1;
        send_frame(8'h09, 16'h0100, 16'h0020);
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        n_checks++;
        if ({o_busy, o_done, o_timeout, o_tx_wr} !== 4'b0 ||
            {o_alu_op, o_alu_a, o_alu_b} !== '0) begin
            n_errors++;
            $display("FAIL midreset_outputs: got busy=%b op=%h a=%h b=%h want all zero",
                     o_busy, o_alu_op, o_alu_a, o_alu_b);
        end
        rx_block = 1'b0;
        set_inputs();
        wait_idle(40, "midreset");
        n_checks++;
        if ({o_alu_op, o_alu_a, o_alu_b} !== {6'h09, 16'h0100, 16'h0020}) begin
            n_errors++;
            $display("FAIL midreset_next_frame: got op=%h a=%h b=%h want op=09 a=0100 b=0020",
                     o_alu_op, o_alu_a, o_alu_b);
        end
    endtask

    task automatic test_back_to_back();
        int d0 = done_seen;
        send_frame(8'h01, 16'h8000, 16'h8000);
        send_frame(8'h3F, 16'h00FF, 16'h0001);
        wait_idle(60, "b2b");
        n_checks++;
        if (done_seen - d0 != 2) begin
            n_errors++;
            $display("FAIL b2b_done_count: got %0d want 2", done_seen - d0);
        end
        n_checks++;
        if ({o_alu_op, o_alu_a, o_alu_b} !== {6'h3F, 16'h00FF, 16'h0001}) begin
            n_errors++;
            $display("FAIL b2b_last_alu: got op=%h a=%h b=%h want op=3f a=00ff b=0001",
                     o_alu_op, o_alu_a, o_alu_b);
        end
    endtask

    task automatic test_random();
        int d0 = done_seen;
        for (int f = 0; f < 6; f++) begin
            gap_len = $urandom_range(0, 2);
            stall_arm = ($urandom_range(0, 1) == 1);
            stall_len = $urandom_range(1, 4);
            send_frame(8'($urandom), 16'($urandom), 16'($urandom));
            wait_idle(60, "random");
        end
        gap_len = 0;
        stall_arm = 1'b0;
        n_checks++;
        if (done_seen - d0 != 6) begin
            n_errors++;
            $display("FAIL random_done_count: got %0d want 6", done_seen - d0);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_gaps();
        test_timeout();
        test_tx_stall();
        test_reset_mid_frame();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_uart_frame_ctrl.md
Name: alu_uart_frame_ctrl

Overview:
Frame controller between the UART RX/TX FIFOs and the ALU, generalised to multi-byte operands. It pops an opcode byte and two little-endian multi-byte operands from the RX FIFO and presents them atomically to the ALU. It then serialises the multi-byte ALU result into the TX FIFO under backpressure. It adds an inter-byte timeout that aborts partial frames.

Parameters:
NB_DATA, 8, UART byte width
NB_OP, 6, ALU opcode width (must be <= NB_DATA)
NB_OPERAND, 16, operand/result width; integer multiple of NB_DATA
TIMEOUT_CYCLES, 100000, consecutive empty cycles mid-frame before abort; 0 disables timeout

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous active-high reset
i_rx_data  in  NB_DATA  RX FIFO head byte (first-word-fall-through, valid when i_rx_empty=0)
i_rx_empty  in  1  RX FIFO empty
o_rx_rd  out  1  RX pop strobe, one byte per cycle
i_tx_full  in  1  TX FIFO full
o_tx_wr  out  1  TX push strobe
o_tx_data  out  NB_DATA  byte pushed when o_tx_wr=1
i_alu_result  in  NB_OPERAND  combinational ALU result
o_alu_op  out  NB_OP  latched opcode
o_alu_a  out  NB_OPERAND  latched operand A
o_alu_b  out  NB_OPERAND  latched operand B
o_busy  out  1  high in every state except IDLE
o_done  out  1  one-cycle pulse after the last result byte is pushed
o_timeout  out  1  one-cycle pulse on frame abort

Behaviour:
- Reset: state IDLE; o_alu_op/a/b=0; o_busy/o_done/o_timeout=0; byte counter, timeout counter and staging/result registers cleared. Reset mid-frame discards all partial data; no write or read strobe follows.
- NBYTES = NB_OPERAND/NB_DATA. Byte order is LSB first for operands and result.
- o_rx_rd is combinational: 1 iff state in {IDLE, GET_A, GET_B} and i_rx_empty=0. The byte is captured on the same edge.
- o_tx_wr is combinational: 1 iff state=SEND and i_tx_full=0. o_tx_data is the low byte of the result shift register.
- IDLE: on pop, opcode staging = i_rx_data[NB_OP-1:0] (upper bits ignored) -> GET_A with byte count 0.
- GET_A: each pop shifts the byte into A staging at position count and increments the count. After NBYTES pops -> GET_B with count 0.
- GET_B: same for B staging. On the final pop, o_alu_op/a/b update simultaneously from staging -> EXEC. The ALU outputs never show partial frames and hold previous values until then.
- EXEC: one cycle. The result shift register loads i_alu_result -> SEND with count 0. Frame latency from last B pop to first possible push is 2 cycles.
- SEND: each push shifts the result register right by NB_DATA and increments the count. While i_tx_full=1 the state holds, with no push and no data change. After NBYTES pushes -> IDLE, with o_done=1 on the cycle after the final push.
- Timeout (TIMEOUT_CYCLES>0, GET_A/GET_B only): the counter increments each cycle with i_rx_empty=1 and clears on any pop and on state entry. On reaching TIMEOUT_CYCLES -> IDLE, with o_timeout=1 the next cycle. Staging is discarded and o_alu_* are unchanged. IDLE, EXEC and SEND never time out; a full TX FIFO can stall SEND indefinitely.
- Back-to-back: a byte present in IDLE the cycle after SEND completes is popped immediately.
- Unreachable state encodings -> IDLE with strobes low.

Test Plan:
- NB_OPERAND=16, RX bytes 0x20,0x34,0x12,0x01,0x00 in consecutive cycles, ALU adds -> o_alu_op=0x20, A=0x1234, B=0x0001 update together; TX pushes 0x35 then 0x12; one o_done pulse.
- Same frame with 3 idle RX cycles between bytes (TIMEOUT_CYCLES=10) -> identical outputs; no o_timeout.
- TIMEOUT_CYCLES=10, send 0x20,0x34 then starve -> o_timeout pulse after 10 empty cycles; state IDLE; o_alu_a/b keep the previous frame's values; next full frame processes correctly.
- i_tx_full=1 for 5 cycles at SEND entry, then 0 -> no o_tx_wr during the stall; then 0x35,0x12 in consecutive cycles; data stable throughout the stall.
- Assert i_reset during GET_B -> all outputs 0 next cycle; remaining RX bytes are treated as a new frame's opcode.
- Two frames queued in RX -> second opcode popped the cycle after returning to IDLE; two o_done pulses; results in order.
